// File: rtl/rti_fifo_scheduler.sv
// Timed-release scheduler behind one RTI FIFO: fetches the head entry, holds it until the timeline
// reaches its timestamp, then strobes it out. Define RTI_SCHED_LATE_DROP_EN to discard late entries.
module rti_fifo_scheduler #(
    parameter int TS_WIDTH     = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  abort,
    input  logic [TS_WIDTH-1:0]   time_now,
    input  logic                  fifo_empty,
    input  logic [127:0]          fifo_dout,
    output logic                  fifo_read,
    output logic                  fifo_flush,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TS_WIDTH-1:0]   out_ts,
    output logic                  late_error,
    output logic [TS_WIDTH-1:0]   late_ts,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY);

    // Past due when the modular distance is non-zero and in the forward half of the ring.
    function automatic logic is_past_due(input logic [TS_WIDTH-1:0] diff);
        return (diff != {TS_WIDTH{1'b0}}) && !diff[TS_WIDTH-1];
    endfunction

    state_t                r_state,       w_state_nxt;
    logic [1:0]            r_lat_cnt,     w_lat_cnt_nxt;
    logic [TS_WIDTH-1:0]   r_head_ts,     w_head_ts_nxt;
    logic [DATA_WIDTH-1:0] r_head_data,   w_head_data_nxt;
    logic                  r_out_valid,   w_out_valid_nxt;
    logic [DATA_WIDTH-1:0] r_out_data,    w_out_data_nxt;
    logic [TS_WIDTH-1:0]   r_out_ts,      w_out_ts_nxt;
    logic                  r_late_error,  w_late_error_nxt;
    logic [TS_WIDTH-1:0]   r_late_ts,     w_late_ts_nxt;
    logic                  r_fifo_flush,  w_fifo_flush_nxt;
    logic                  r_abort_blk,   w_abort_blk_nxt;
    logic                  w_fetch;
    logic [TS_WIDTH-1:0]   w_diff;

    // Next-state and next-output computation.
    always_comb begin
        w_state_nxt      = r_state;
        w_lat_cnt_nxt    = r_lat_cnt;
        w_head_ts_nxt    = r_head_ts;
        w_head_data_nxt  = r_head_data;
        w_out_valid_nxt  = 1'b0;
        w_out_data_nxt   = r_out_data;
        w_out_ts_nxt     = r_out_ts;
        w_late_error_nxt = 1'b0;
        w_late_ts_nxt    = r_late_ts;
        w_fifo_flush_nxt = abort && !r_abort_blk;
        w_abort_blk_nxt  = abort;
        w_diff           = time_now - r_head_ts;
        // The abort cycle and the one after it never fetch, so a flush cannot race a read.
        w_fetch          = (r_state == ST_IDLE) && enable && !fifo_empty
                           && !abort && !r_abort_blk && !reset;

        if (abort) begin
            w_state_nxt     = ST_IDLE;
            w_lat_cnt_nxt   = 2'd0;
            w_head_ts_nxt   = {TS_WIDTH{1'b0}};
            w_head_data_nxt = {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fetch) begin
                        w_state_nxt   = ST_WAIT;
                        w_lat_cnt_nxt = 2'd0;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        w_head_ts_nxt   = fifo_dout[127 -: TS_WIDTH];
                        w_head_data_nxt = fifo_dout[DATA_WIDTH-1:0];
                        w_state_nxt     = ST_ARMED;
                    end else begin
                        w_lat_cnt_nxt   = r_lat_cnt + 2'd1;
                    end
                end
                ST_ARMED: begin
                    if (w_diff == {TS_WIDTH{1'b0}}) begin
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = r_head_data;
                        w_out_ts_nxt    = r_head_ts;
                        w_state_nxt     = ST_IDLE;
                    end else if (is_past_due(w_diff)) begin
                        w_late_error_nxt = 1'b1;
                        w_late_ts_nxt    = r_head_ts;
`ifdef RTI_SCHED_LATE_DROP_EN
                        w_out_valid_nxt  = 1'b0;
`else
                        w_out_valid_nxt  = 1'b1;
                        w_out_data_nxt   = r_head_data;
                        w_out_ts_nxt     = r_head_ts;
`endif
                        w_state_nxt      = ST_IDLE;
                    end else begin
                        w_state_nxt      = ST_ARMED;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_lat_cnt    <= 2'd0;
            r_head_ts    <= {TS_WIDTH{1'b0}};
            r_head_data  <= {DATA_WIDTH{1'b0}};
            r_out_valid  <= 1'b0;
            r_out_data   <= {DATA_WIDTH{1'b0}};
            r_out_ts     <= {TS_WIDTH{1'b0}};
            r_late_error <= 1'b0;
            r_late_ts    <= {TS_WIDTH{1'b0}};
            r_fifo_flush <= 1'b0;
            r_abort_blk  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lat_cnt    <= w_lat_cnt_nxt;
            r_head_ts    <= w_head_ts_nxt;
            r_head_data  <= w_head_data_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_ts     <= w_out_ts_nxt;
            r_late_error <= w_late_error_nxt;
            r_late_ts    <= w_late_ts_nxt;
            r_fifo_flush <= w_fifo_flush_nxt;
            r_abort_blk  <= w_abort_blk_nxt;
        end
    end

    assign fifo_read  = w_fetch;
    assign fifo_flush = r_fifo_flush;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_ts     = r_out_ts;
    assign late_error = r_late_error;
    assign late_ts    = r_late_ts;
    assign busy       = (r_state != ST_IDLE);

endmodule
